// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: RV32I load/store size codes,
// sequencer states and the power-on fill pattern.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // Counting pattern in the low words, zero everywhere else.
    function automatic logic [31:0] init_pattern(input logic [31:0]  idx,
                                                 input int unsigned  init_words,
                                                 input logic [31:0]  init_base);
        logic [31:0] val;
        val = '0;
        if (idx < init_words) begin
            val = init_base + idx;
        end
        return val;
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// CPU-side data memory bus: store/load request from the core and the memory's
// response, status and fault reporting.
interface dmem_bytelane_if;

    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        fault;
    logic        fault_sticky;
    logic [31:0] fault_addr;

    modport master (
        output we, funct3, addr, wdata,
        input  rdata, ready, fault, fault_sticky, fault_addr
    );

    modport slave (
        input  we, funct3, addr, wdata,
        output rdata, ready, fault, fault_sticky, fault_addr
    );

endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for one 32-bit word: store byte enables and replicated store
// data, load lane selection with sign/zero extension, and natural-alignment check.
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be_o       = '0;
        wdata_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (funct3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'b0, byte_sel};
            end
            F3_H, F3_HU: begin
                be_o       = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = (funct3_i == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                                : {16'b0, half_sel};
                misalign_o = lane_i[0];
            end
            F3_W: begin
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = word_i;
                misalign_o = |lane_i;
            end
            default: begin
                be_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed RV32I data memory with post-reset fill sequencer and fault capture.
// Define DMEM_MISALIGN_CHK_EN to treat misaligned half/word accesses as faults.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned INIT_WORDS = 10,
    parameter logic [31:0] INIT_BASE  = 32'd1
) (
    input  logic             clk,
    input  logic             rstn,
    dmem_bytelane_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit misalign_chk = 1'b1;
`else
    localparam bit misalign_chk = 1'b0;
`endif

    logic [31:0]   mem_q [DEPTH];
    state_e        state_q;
    logic [AW-1:0] init_ptr_q;
    logic          ready_q;
    logic          fault_sticky_q;
    logic [31:0]   fault_addr_q;

    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic          f3_ok;
    logic          illegal;
    logic          fault_c;
    logic [31:0]   rd_word;
    logic [3:0]    be;
    logic [31:0]   st_data;
    logic [31:0]   ld_data;
    logic          misalign;
    logic          init_we;
    logic          cpu_we;

    assign word_idx     = bus.addr[AW+1:2];
    assign out_of_range = |bus.addr[31:AW+2];
    assign rd_word      = mem_q[word_idx];

    // Unsigned load codes have no store counterpart.
    always_comb begin
        f3_ok = 1'b0;
        case (bus.funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = ~bus.we;
            default:          f3_ok = 1'b0;
        endcase
    end

    dmem_lane_ctrl u_lane_ctrl (
        .funct3_i   (bus.funct3),
        .lane_i     (bus.addr[1:0]),
        .wdata_i    (bus.wdata),
        .word_i     (rd_word),
        .be_o       (be),
        .wdata_o    (st_data),
        .rdata_o    (ld_data),
        .misalign_o (misalign)
    );

    assign illegal = out_of_range | ~f3_ok | (misalign_chk & misalign);
    assign fault_c = ready_q & illegal;
    assign init_we = rstn & (state_q == ST_INIT);
    assign cpu_we  = rstn & ready_q & bus.we & ~illegal;

    assign bus.rdata        = (ready_q && !illegal) ? ld_data : '0;
    assign bus.fault        = fault_c;
    assign bus.ready        = ready_q;
    assign bus.fault_sticky = fault_sticky_q;
    assign bus.fault_addr   = fault_addr_q;

    // Array write port: fill sequencer while initialising, masked CPU stores afterwards.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_ptr_q] <= init_pattern(32'(init_ptr_q), INIT_WORDS, INIT_BASE);
        end else if (cpu_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

    // Sequencer and first-fault capture; only the first fault after reset is kept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ST_INIT;
            init_ptr_q     <= '0;
            ready_q        <= 1'b0;
            fault_sticky_q <= 1'b0;
            fault_addr_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + AW'(1);
                    if (init_ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fault_c && !fault_sticky_q) begin
                        fault_sticky_q <= 1'b1;
                        fault_addr_q   <= bus.addr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane against a word-array reference model.
module tb_dmem_bytelane;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mm [DEPTH];
    logic        m_sticky;
    logic [31:0] m_faddr;

    dmem_bytelane_if bus ();

    dmem_bytelane #(.DEPTH(DEPTH), .INIT_WORDS(10), .INIT_BASE(32'd1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        bad = (a >= 32'(DEPTH * 4));
        case (f3)
            3'd0: ;
            3'd1: if (CHK && (a % 2 != 0)) bad = 1'b1;
            3'd2: if (CHK && (a % 4 != 0)) bad = 1'b1;
            3'd4: if (we) bad = 1'b1;
            3'd5: if (we || (CHK && (a % 2 != 0))) bad = 1'b1;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] m_expect(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w, v;
        int sh;
        if (m_illegal(we, f3, a)) return 32'h0;
        w = mm[a / 4];
        v = w;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            sh = int'(a % 4) * 8;
            v = (w >> sh) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            sh = int'((a / 2) % 2) * 16;
            v = (w >> sh) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sh;
        logic [31:0] msk;
        if (f3 == 3'd0) begin
            sh = int'(a % 4) * 8;
            msk = 32'hFF << sh;
            mm[a / 4] = (mm[a / 4] & ~msk) | ((d & 32'hFF) << sh);
        end else if (f3 == 3'd1) begin
            sh = int'((a / 2) % 2) * 16;
            msk = 32'hFFFF << sh;
            mm[a / 4] = (mm[a / 4] & ~msk) | ((d & 32'hFFFF) << sh);
        end else begin
            mm[a / 4] = d;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(DEPTH); i++) mm[i] = (i < 10) ? 32'(i + 1) : 32'h0;
        m_sticky = 1'b0;
        m_faddr  = 32'h0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
        #1;
    endtask

    // One RUN-state clock edge, with the model advanced to match.
    task automatic tick();
        logic flt;
        flt = m_illegal(bus.we, bus.funct3, bus.addr);
        if (bus.we && !flt) m_store(bus.funct3, bus.addr, bus.wdata);
        if (flt && !m_sticky) begin m_sticky = 1'b1; m_faddr = bus.addr; end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rstn = 1'b0;
        drive(1'b0, 3'd2, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.ready); end
        checks++; if (bus.fault_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", bus.fault_sticky); end
        checks++; if (bus.fault_addr !== 32'h0) begin errors++; $display("FAIL reset_faddr got %h exp 0", bus.fault_addr); end
        m_reset();
        rstn = 1'b1;
        n = 0;
        // Stores and illegal accesses during fill must be invisible.
        while (bus.ready !== 1'b1 && n < int'(DEPTH) + 8) begin
            if (n % 2 == 0) drive(1'b1, 3'd2, 32'h0, 32'hDEADBEEF);
            else            drive(1'b0, 3'd7, 32'h400, 32'h0);
            checks++;
            if (bus.rdata !== 32'h0 || bus.fault !== 1'b0) begin
                errors++; $display("FAIL init_quiet cyc %0d rdata %h fault %b exp 0/0", n, bus.rdata, bus.fault);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != int'(DEPTH)) begin errors++; $display("FAIL ready_latency got %0d exp %0d", n, DEPTH); end
    endtask

    task automatic test_init_pattern();
        logic [31:0] a;
        drive(1'b0, F3_W, 32'h0, 32'h0);
        checks++; if (bus.rdata !== 32'd1) begin errors++; $display("FAIL lw_0 got %h exp 1", bus.rdata); end
        tick();
        drive(1'b0, F3_W, 32'h24, 32'h0);
        checks++; if (bus.rdata !== 32'd10) begin errors++; $display("FAIL lw_24 got %h exp a", bus.rdata); end
        tick();
        drive(1'b0, F3_W, 32'h28, 32'h0);
        checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL lw_28 got %h exp 0", bus.rdata); end
        tick();
        drive(1'b0, F3_W, 32'h3FC, 32'h0);
        checks++; if (bus.rdata !== 32'd0 || bus.fault !== 1'b0) begin errors++; $display("FAIL lw_3fc got %h/%b exp 0/0", bus.rdata, bus.fault); end
        tick();
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            drive(1'b0, F3_W, a, 32'h0);
            checks++; if (bus.rdata !== m_expect(1'b0, F3_W, a)) begin errors++; $display("FAIL init_word %h got %h exp %h", a, bus.rdata, m_expect(1'b0, F3_W, a)); end
            tick();
        end
    endtask

    task automatic test_load_ext();
        drive(1'b1, F3_W, 32'h40, 32'h80FF7F01);
        tick();
        drive(1'b0, F3_B, 32'h43, 32'h0);
        checks++; if (bus.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_43 got %h exp ffffff80", bus.rdata); end
        tick();
        drive(1'b0, F3_BU, 32'h41, 32'h0);
        checks++; if (bus.rdata !== 32'h0000007F) begin errors++; $display("FAIL lbu_41 got %h exp 0000007f", bus.rdata); end
        tick();
        drive(1'b0, F3_H, 32'h42, 32'h0);
        checks++; if (bus.rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_42 got %h exp ffff80ff", bus.rdata); end
        tick();
        drive(1'b0, F3_HU, 32'h40, 32'h0);
        checks++; if (bus.rdata !== 32'h00007F01) begin errors++; $display("FAIL lhu_40 got %h exp 00007f01", bus.rdata); end
        tick();
    endtask

    task automatic test_partial_store();
        drive(1'b1, F3_W, 32'h50, 32'hAABBCCDD); tick();
        drive(1'b1, F3_B, 32'h51, 32'h00000011); tick();
        drive(1'b0, F3_W, 32'h50, 32'h0);
        checks++; if (bus.rdata !== 32'hAABB11DD) begin errors++; $display("FAIL sb_51 got %h exp aabb11dd", bus.rdata); end
        tick();
        drive(1'b1, F3_H, 32'h52, 32'h00002233); tick();
        drive(1'b0, F3_W, 32'h50, 32'h0);
        checks++; if (bus.rdata !== 32'h223311DD) begin errors++; $display("FAIL sh_52 got %h exp 223311dd", bus.rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, F3_W, 32'h80, 32'h11223344); tick();
        drive(1'b1, F3_W, 32'h80, 32'h55667788);
        checks++; if (bus.rdata !== 32'h11223344) begin errors++; $display("FAIL rw_same_cycle got %h exp 11223344", bus.rdata); end
        tick();
        drive(1'b0, F3_W, 32'h80, 32'h0);
        checks++; if (bus.rdata !== 32'h55667788) begin errors++; $display("FAIL rw_next_cycle got %h exp 55667788", bus.rdata); end
        tick();
        drive(1'b1, F3_B, 32'h84, 32'hA1); tick();
        drive(1'b1, F3_B, 32'h85, 32'hB2); tick();
        drive(1'b1, F3_B, 32'h86, 32'hC3); tick();
        drive(1'b1, F3_B, 32'h87, 32'hD4); tick();
        drive(1'b0, F3_W, 32'h84, 32'h0);
        checks++; if (bus.rdata !== 32'hD4C3B2A1) begin errors++; $display("FAIL sb_burst got %h exp d4c3b2a1", bus.rdata); end
        tick();
    endtask

    task automatic test_fault_capture();
        checks++; if (bus.fault_sticky !== 1'b0) begin errors++; $display("FAIL pre_fault_sticky got %b exp 0", bus.fault_sticky); end
`ifdef DMEM_MISALIGN_CHK_EN
        drive(1'b1, F3_W, 32'h61, 32'h12345678);
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL sw_61_fault got %b exp 1", bus.fault); end
        tick();
        checks++; if (bus.fault_sticky !== 1'b1 || bus.fault_addr !== 32'h61) begin errors++; $display("FAIL sw_61_capture got %b/%h exp 1/61", bus.fault_sticky, bus.fault_addr); end
        drive(1'b0, F3_W, 32'h60, 32'h0);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL sw_61_dropped got %h exp 0", bus.rdata); end
        tick();
        drive(1'b0, F3_W, 32'h400, 32'h0);
        checks++; if (bus.fault !== 1'b1 || bus.rdata !== 32'h0) begin errors++; $display("FAIL lw_400 got %b/%h exp 1/0", bus.fault, bus.rdata); end
        tick();
        checks++; if (bus.fault_addr !== 32'h61) begin errors++; $display("FAIL first_fault_kept got %h exp 61", bus.fault_addr); end
`else
        drive(1'b1, F3_W, 32'h61, 32'h12345678);
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL sw_61_fault got %b exp 0", bus.fault); end
        tick();
        drive(1'b0, F3_W, 32'h60, 32'h0);
        checks++; if (bus.rdata !== 32'h12345678 || bus.fault_sticky !== 1'b0) begin errors++; $display("FAIL sw_61_aligned got %h/%b exp 12345678/0", bus.rdata, bus.fault_sticky); end
        tick();
        drive(1'b0, F3_W, 32'h400, 32'h0);
        checks++; if (bus.fault !== 1'b1 || bus.rdata !== 32'h0) begin errors++; $display("FAIL lw_400 got %b/%h exp 1/0", bus.fault, bus.rdata); end
        tick();
        checks++; if (bus.fault_sticky !== 1'b1 || bus.fault_addr !== 32'h400) begin errors++; $display("FAIL lw_400_capture got %b/%h exp 1/400", bus.fault_sticky, bus.fault_addr); end
        drive(1'b0, 3'd3, 32'h10, 32'h0);
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL f3_011_fault got %b exp 1", bus.fault); end
        tick();
        checks++; if (bus.fault_addr !== 32'h400) begin errors++; $display("FAIL first_fault_kept got %h exp 400", bus.fault_addr); end
`endif
    endtask

    task automatic test_random(input int ops);
        logic [2:0]  f3;
        logic [31:0] a, d, er;
        logic        we, ef;
        for (int i = 0; i < ops; i++) begin
            case ($urandom_range(0, 5))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                4: f3 = 3'd5;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            a  = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, DEPTH * 4 - 1));
            we = 1'($urandom_range(0, 1));
            d  = 32'($urandom);
            drive(we, f3, a, d);
            er = m_expect(we, f3, a);
            ef = m_illegal(we, f3, a);
            checks++; if (bus.rdata !== er) begin errors++; $display("FAIL rnd_rdata op %0d f3 %0d a %h got %h exp %h", i, f3, a, bus.rdata, er); end
            checks++; if (bus.fault !== ef) begin errors++; $display("FAIL rnd_fault op %0d f3 %0d we %b a %h got %b exp %b", i, f3, we, a, bus.fault, ef); end
            tick();
            checks++; if (bus.fault_sticky !== m_sticky || bus.fault_addr !== m_faddr) begin errors++; $display("FAIL rnd_sticky op %0d got %b/%h exp %b/%h", i, bus.fault_sticky, bus.fault_addr, m_sticky, m_faddr); end
        end
    endtask

    task automatic test_midrun_reset();
        int n;
        drive(1'b1, F3_W, 32'h8, 32'h0000DEAD); tick();
        drive(1'b0, F3_W, 32'h400, 32'h0); tick();
        rstn = 1'b0;
        drive(1'b0, F3_W, 32'h8, 32'h0);
        @(posedge clk); #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midrun_ready got %b exp 0", bus.ready); end
        checks++; if (bus.fault_sticky !== 1'b0 || bus.fault_addr !== 32'h0) begin errors++; $display("FAIL midrun_sticky got %b/%h exp 0/0", bus.fault_sticky, bus.fault_addr); end
        m_reset();
        rstn = 1'b1;
        n = 0;
        while (bus.ready !== 1'b1 && n < int'(DEPTH) + 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != int'(DEPTH)) begin errors++; $display("FAIL reinit_latency got %0d exp %0d", n, DEPTH); end
        drive(1'b0, F3_W, 32'h8, 32'h0);
        checks++; if (bus.rdata !== 32'd3) begin errors++; $display("FAIL reinit_lw_8 got %h exp 3", bus.rdata); end
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        bus.we = 1'b0; bus.funct3 = 3'd2; bus.addr = 32'h0; bus.wdata = 32'h0;
        test_reset();
        test_init_pattern();
        test_load_ext();
        test_partial_store();
        test_back_to_back();
        test_fault_capture();
        test_random(300);
        test_midrun_reset();
        test_random(150);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor to the single-cycle CPU data memory.
- Byte-addressed, word-organised RAM with full RV32I load/store width support: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Writes are synchronous; reads are combinational, matching the single-cycle datapath.
- A post-reset initialisation sequencer walks the array and asserts ready when it finishes; the core stalls until ready is high.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 16; AW = clog2(DEPTH) is derived.
- INIT_WORDS, 10, number of low words preloaded with a counting pattern; must be at most DEPTH.
- INIT_BASE, 1, value written to word 0; word i receives INIT_BASE+i for i < INIT_WORDS, and 0 otherwise.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  reset, synchronous, active-low
- we  in  1  store enable, one store per cycle
- funct3  in  3  access size/sign, RV32I encoding
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- rdata  out  32  load data, sign/zero-extended
- ready  out  1  initialisation complete
- fault  out  1  misaligned or illegal access this cycle (combinational)
- fault_sticky  out  1  a fault has occurred since reset
- fault_addr  out  32  address of the first fault since reset

Behaviour:
- Reset: a clock edge with rstn=0 sets state=INIT, init_ptr=0, ready=0, fault_sticky=0, fault_addr=0. A reset asserted mid-operation or mid-INIT restarts INIT from word 0.
- INIT state:
  - Each cycle writes mem[init_ptr] with the init pattern, then increments init_ptr.
  - On the edge that writes word DEPTH-1, state goes to RUN and ready=1.
  - So ready rises exactly DEPTH cycles after the first edge with rstn=1.
- RUN state: holds until reset. There are no other transitions.
- While ready=0:
  - CPU stores are ignored.
  - rdata=0 and fault=0.
- Address decode:
  - word index = addr[AW+1:2]; lane = addr[1:0].
  - Out of range when addr[31:AW+2] != 0. An out-of-range access is illegal: rdata=0, store dropped, fault=1.
- funct3 decode:
  - 000 = byte signed; 001 = half signed; 010 = word; 100 = byte unsigned; 101 = half unsigned.
  - Any other code is illegal: rdata=0, store dropped, fault=1.
  - Stores use size only. funct3 100/101 combined with we=1 is illegal.
- Loads:
  - Byte loads select lane addr[1:0].
  - Half loads select addr[1] (bits 15:0 or 31:16).
  - Results are sign- or zero-extended to 32 bits.
- Stores, at the rising edge when ready & we & legal:
  - SB writes only byte lane addr[1:0] with wdata[7:0].
  - SH writes the half selected by addr[1] with wdata[15:0].
  - SW writes the full word.
  - Unselected bytes are preserved.
- Read and write to the same word in the same cycle: rdata returns the pre-write contents; the new value is visible from the next cycle.
- fault_sticky / fault_addr:
  - On the first edge in RUN with fault=1, fault_addr captures addr and fault_sticky is set.
  - Later faults do not overwrite either until reset.
- fault is evaluated for loads every cycle in RUN. A bench treats fault as meaningful only when the core qualifies the instruction as a memory access.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is illegal. It gives rdata=0, the store is dropped, fault=1, and it is captured in fault_addr/fault_sticky.
- Undefined: misalignment is not checked. Half accesses ignore addr[0] and word accesses ignore addr[1:0]; data is truncated to the naturally aligned container. fault/fault_sticky still report out-of-range and illegal funct3.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum {ST_INIT, ST_RUN};
  - a function computing the init pattern.
- One sub-module, dmem_lane_ctrl (combinational):
  - takes funct3, addr[1:0], wdata and the current word;
  - produces the 4-bit byte-enable mask, the shifted write data, the extended load data and the misalign flag.
- The top level owns the array, the sequencer and the fault registers.

Test Plan:
- Release reset, DEPTH=256 -> ready=0 for 256 cycles then 1; LW 0x0=1, LW 0x24=10, LW 0x28=0, LW 0x3FC=0.
- SW 0x40 = 0x80FF7F01, then LB 0x43 -> 0xFFFFFF80, LBU 0x41 -> 0x0000007F, LH 0x42 -> 0xFFFF80FF, LHU 0x40 -> 0x00007F01.
- SW 0x50 = 0xAABBCCDD, then SB 0x51 = 0x11 -> LW 0x50 = 0xAABB11DD; SH 0x52 = 0x2233 -> LW 0x50 = 0x223311DD.
- With DMEM_MISALIGN_CHK_EN, SW 0x61 = 0x12345678 -> fault=1, word 0x60 unchanged, fault_addr=0x61, fault_sticky=1. A later fault at 0x400 leaves fault_addr=0x61.
- Store during INIT (we=1, addr 0x0) -> ignored; after ready, LW 0x0=1.
- Assert rstn=0 after an SW 0x8 = 0xDEAD, mid-run -> ready drops next edge; after re-init, LW 0x8=3 and fault_sticky=0.
